// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller for the 5-stage core.
// Produces registered execute-stage operand selects, a writeback-to-decode
// bypass, load-use stalls, branch flushes and the multiplier stall FSM.
module hazard_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 3,
  parameter int FWD_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr_d,
  input  logic [REG_ADDR_W-1:0] rs2_addr_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic [REG_ADDR_W-1:0] rd_addr_e,
  input  logic                  reg_write_en_e,
  input  logic                  dmem_read_en_e,
  input  logic                  mul_start_e,
  input  logic                  branch_taken_e,
  input  logic [REG_ADDR_W-1:0] rd_addr_m,
  input  logic                  reg_write_en_m,
  input  logic [REG_ADDR_W-1:0] rd_addr_w,
  input  logic                  reg_write_en_w,
  output logic [1:0]            alumul_data1_sel_e,
  output logic [1:0]            alumul_forward_sel_e,
  output logic                  wb_bypass1_d,
  output logic                  wb_bypass2_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_fd,
  output logic                  flush_de,
  output logic                  bubble_em,
  output logic                  mul_busy,
  output logic                  mul_done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

  // Counter only needs to reach MUL_LATENCY-2 (at most 14).
  localparam int               CNT_W     = 4;
  localparam bit               MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = MUL_MULTI ? CNT_W'(MUL_LATENCY - 2) : '0;

  logic                  post_reset_reg;
  logic                  blank;
  mul_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  mul_stall;
  logic                  mul_last;
  logic                  load_use;
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            src_used;
  logic [1:0]            match_e, match_m, match_w;
  logic [1:0]            fwd_sel [2];
  logic [1:0]            bypass;

  assign src_addr[0] = rs1_addr_d;
  assign src_addr[1] = rs2_addr_d;
  assign src_used    = {rs2_used_d, rs1_used_d};

  // Outputs stay quiet during reset and the cycle after it.
  assign blank = reset || post_reset_reg;

  // Remember that the previous cycle was a reset cycle.
  always_ff @(posedge clk) begin
    post_reset_reg <= reset;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic       src_live;
      logic [1:0] sel_next;
      logic [1:0] sel_reg;

      // x0 and unused sources never match anything.
      assign src_live    = src_used[gi] && (src_addr[gi] != '0);
      assign match_e[gi] = src_live && reg_write_en_e && (src_addr[gi] == rd_addr_e);
      assign match_m[gi] = src_live && reg_write_en_m && (src_addr[gi] == rd_addr_m);
      assign match_w[gi] = src_live && reg_write_en_w && (src_addr[gi] == rd_addr_w);

      // Select the youngest producer: execute result beats memory result.
      always_comb begin
        sel_next = 2'b00;
        if (FWD_EN != 0) begin
          if (match_e[gi]) begin
            sel_next = 2'b01;
          end else if (match_m[gi]) begin
            sel_next = 2'b10;
          end
        end
      end

      // Select register follows DE_EX: bubble clears it, stall holds it.
      always_ff @(posedge clk) begin
        if (blank) begin
          sel_reg <= 2'b00;
        end else if (flush_de) begin
          sel_reg <= 2'b00;
        end else if (!stall_e) begin
          sel_reg <= sel_next;
        end
      end

      assign fwd_sel[gi] = blank ? 2'b00 : sel_reg;
      assign bypass[gi]  = (FWD_EN != 0) && !blank && match_w[gi];
    end
  endgenerate

  assign alumul_data1_sel_e   = fwd_sel[0];
  assign alumul_forward_sel_e = fwd_sel[1];
  assign wb_bypass1_d         = bypass[0];
  assign wb_bypass2_d         = bypass[1];

  // A load in execute feeding a decode source must wait one cycle.
  assign load_use = dmem_read_en_e && (match_e != 2'b00);

  // Multiply FSM state and countdown register.
  always_ff @(posedge clk) begin
    if (blank) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Multiply FSM next state: stall until the final occupancy cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mul_stall  = 1'b0;
    mul_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MUL_MULTI && mul_start_e && !branch_taken_e) begin
          mul_stall  = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          mul_stall = 1'b1;
          cnt_next  = cnt_reg - CNT_W'(1);
        end else begin
          mul_last   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Pipeline control with priority branch > multiply > load-use.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    bubble_em = 1'b0;
    if (!blank) begin
      if (branch_taken_e) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (mul_stall) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        stall_e   = 1'b1;
        bubble_em = 1'b1;
      end else if (load_use) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_de = 1'b1;
      end
    end
  end

  assign mul_busy = !blank && (state_reg == BUSY);
  assign mul_done = !blank && mul_last;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage core (Fetch, Decode, Execute, Memory, Writeback).
- Replaces the constant-zero forwarding selects and branch-only flushing the core uses today.
- Generates registered execute-stage forwarding selects, a Writeback-to-Decode same-cycle bypass, load-use stalls, branch flushes, and a stall FSM for a multi-cycle multiplier.

Parameters:
REG_ADDR_W, 5, register address width
MUL_LATENCY, 3, execute-stage occupancy of a multiply in cycles; legal range 1..16; 1 means no stall
FWD_EN, 1, 0 ties both forwarding selects and both wb_bypass outputs to 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rs1_addr_d  in  REG_ADDR_W  decode source 1
rs2_addr_d  in  REG_ADDR_W  decode source 2
rs1_used_d  in  1  decode instruction reads rs1
rs2_used_d  in  1  decode instruction reads rs2
rd_addr_e  in  REG_ADDR_W  execute destination
reg_write_en_e  in  1  execute writes a register
dmem_read_en_e  in  1  execute instruction is a load
mul_start_e  in  1  multiply present in execute
branch_taken_e  in  1  redirect (pc_branch_en_sel[1])
rd_addr_m  in  REG_ADDR_W  memory-stage destination
reg_write_en_m  in  1  memory-stage write enable
rd_addr_w  in  REG_ADDR_W  writeback destination
reg_write_en_w  in  1  writeback write enable
alumul_data1_sel_e  out  2  operand-1 source: 00 regfile, 01 execute_out_m, 10 execute_out_w
alumul_forward_sel_e  out  2  operand-2 source, same encoding
wb_bypass1_d  out  1  decode rs1 takes reg_writedata_w
wb_bypass2_d  out  1  decode rs2 takes reg_writedata_w
stall_f  out  1  hold PC
stall_d  out  1  hold FE_DE
stall_e  out  1  hold DE_EX
flush_fd  out  1  bubble into FE_DE
flush_de  out  1  bubble into DE_EX
bubble_em  out  1  bubble into EX_MEM
mul_busy  out  1  FSM in BUSY
mul_done  out  1  final execute cycle of a multi-cycle multiply

Behaviour:
- Reset:
  - All outputs are 0 in the cycle reset is high and in the cycle after.
  - Select registers clear to 00. FSM goes to IDLE. Counter clears to 0.
  - Reset aborts an in-flight multiply.
- Match rule: a source matches a stage when addresses are equal, that stage's write enable is 1, the address is nonzero, and the source's used bit is 1. x0 is never forwarded or bypassed.
- Forwarding selects:
  - Computed in Decode, registered into Execute, so they are valid 1 cycle after DE_EX loads.
  - Next value: match on rd_addr_e gives 01; else match on rd_addr_m gives 10; else 00. The execute match takes priority over the memory match.
  - Register update: load 00 when flush_de=1; hold when stall_e=1; otherwise load the computed value.
- wb_bypass1_d / wb_bypass2_d: combinational; 1 on a match against rd_addr_w.
- Load-use hazard:
  - Condition: dmem_read_en_e=1 and a decode source matches rd_addr_e.
  - Response: stall_f=stall_d=flush_de=1 for exactly 1 cycle.
  - The stalled instruction then computes select 10 (load now in M).
- Multiply FSM, states IDLE and BUSY:
  - IDLE with mul_start_e=1 and MUL_LATENCY>1: stall=1, cnt<=MUL_LATENCY-2, go to BUSY.
  - BUSY with cnt!=0: stall=1, cnt decrements.
  - BUSY with cnt==0: stall=0, mul_done=1, go to IDLE.
  - mul_start_e is ignored while in BUSY.
  - Totals: MUL_LATENCY-1 stall cycles and MUL_LATENCY cycles of execute occupancy.
  - MUL_LATENCY=1: FSM never leaves IDLE; mul_done is never asserted.
  - The multiplier latches its operands in the first execute cycle; the forwarding selects are required correct only in that cycle.
- Multiply stall: stall_f=stall_d=stall_e=bubble_em=1 and flush_de=0.
- Priority, highest first: reset, branch_taken_e, multiply stall, load-use.
- Branch: flush_fd=flush_de=1; stall_f=stall_d=0 in the same cycle, which cancels a concurrent load-use stall.
- Simultaneous events:
  - Load-use is evaluated only when the multiply stall is inactive. Execute then holds the multiply, which is not a load, so the two never overlap.
  - branch_taken_e and mul_start_e are mutually exclusive by decode. If both are seen, branch wins and the FSM stays IDLE.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 back-to-back -> the cycle after the consumer enters Execute, alumul_data1_sel_e=01 and alumul_forward_sel_e=00.
- Producer of x5 two slots ahead -> consumer sees sel=10. Three slots ahead -> wb_bypass1_d=1 in decode and sel=00. Producer writes x0 -> all 0.
- lw x7 then add x8,x7,x1 -> one cycle of stall_f=stall_d=flush_de=1, then the add in Execute has alumul_data1_sel_e=10 and no further stall.
- MUL_LATENCY=3, mul x9 in Execute -> stall_e=bubble_em=1 for 2 cycles, mul_busy=1 in cycle 2, mul_done=1 in cycle 3, dependent add gets sel=01. Repeat with MUL_LATENCY=1 and 16 -> 0 and 15 stall cycles.
- branch_taken_e=1 in the same cycle as a load-use condition -> flush_fd=flush_de=1 and stall_f=stall_d=0.
- reset asserted in the 2nd BUSY cycle (MUL_LATENCY=4) -> next cycle mul_busy=0 and every stall/flush/select output is 0; a fresh mul then stalls for exactly 3 cycles.
